// File: rtl/func_arbiter_pkg.sv
// func_arbiter_pkg: shared types for the function-arbiter call/return protocol.
// Holds the child FSM state encoding, the latched call context and the default
// data widths used by the child-side responder.
package func_arbiter_pkg;

    localparam int THREAD     = 16;
    localparam int PARENT     = 32;
    localparam int SEQ        = 8;
    localparam int ARG_W      = 32;
    localparam int ARG_NUM    = 8;
    localparam int RET_DW     = 32;
    localparam int LOG_THREAD = (THREAD > 1) ? $clog2(THREAD) : 1;
    localparam int LOG_PARENT = (PARENT > 1) ? $clog2(PARENT) : 1;
    localparam int LOG_SEQ    = $clog2(SEQ);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_RET  = 2'd2
    } state_t;

    typedef struct packed {
        logic [LOG_THREAD-1:0]    thread;
        logic [LOG_PARENT-1:0]    parent;
        logic [ARG_W-1:0]         pc;
        logic [ARG_NUM*ARG_W-1:0] args;
        logic [LOG_SEQ-1:0]       call_seq;
        logic [1:0]               ret_req;
    } call_ctx_t;

endpackage

// File: rtl/func_child_ctx_buf.sv
// func_child_ctx_buf: active call context plus an optional one-entry pending slot.
// Optional feature macro: FUNC_CHILD_CALLBUF_EN (compiles in the pending slot).
// push loads the active slot when it is free, otherwise the pending slot; pop
// retires the active call and promotes the pending one if present.
module func_child_ctx_buf
    import func_arbiter_pkg::*;
(
    input  logic      clk,
    input  logic      rstn,
    input  logic      push,
    input  call_ctx_t din,
    input  logic      pop,
    output call_ctx_t act,
    output logic      full,
    output logic      empty,
    output logic      pending
);

    call_ctx_t act_r;
    logic      act_vld_r;

`ifdef FUNC_CHILD_CALLBUF_EN
    call_ctx_t pend_r;
    logic      pend_vld_r;

    // Active/pending slot update; push is never presented while the pending slot is full.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            act_r      <= '0;
            act_vld_r  <= 1'b0;
            pend_r     <= '0;
            pend_vld_r <= 1'b0;
        end else if (pop) begin
            if (pend_vld_r) begin
                act_r      <= pend_r;
                pend_vld_r <= 1'b0;
            end else if (push) begin
                act_r     <= din;
                act_vld_r <= 1'b1;
            end else begin
                act_vld_r <= 1'b0;
            end
        end else if (push) begin
            if (!act_vld_r) begin
                act_r     <= din;
                act_vld_r <= 1'b1;
            end else begin
                pend_r     <= din;
                pend_vld_r <= 1'b1;
            end
        end
    end

    assign full    = pend_vld_r;
    assign pending = pend_vld_r;
`else
    // Single active slot: load on push, release on pop.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            act_r     <= '0;
            act_vld_r <= 1'b0;
        end else if (push) begin
            act_r     <= din;
            act_vld_r <= 1'b1;
        end else if (pop) begin
            act_vld_r <= 1'b0;
        end
    end

    assign full    = act_vld_r;
    assign pending = 1'b0;
`endif

    assign act   = act_r;
    assign empty = !act_vld_r;

endmodule

// File: rtl/func_child_port.sv
// func_child_port: child-side responder of the function-arbiter protocol.
// Optional feature macro: FUNC_CHILD_CALLBUF_EN (one pending call may queue
// behind the active one). Drives the kernel ap_ctrl_hs start handshake and
// holds the return channel until the arbiter accepts it.
module func_child_port
    import func_arbiter_pkg::*;
#(
    parameter int THREAD     = 16,
    parameter int PARENT     = 32,
    parameter int SEQ        = 8,
    parameter int ARG_W      = 32,
    parameter int ARG_NUM    = 8,
    parameter int RET_DW     = 32,
    parameter int LOG_THREAD = (THREAD > 1) ? $clog2(THREAD) : 1,
    parameter int LOG_PARENT = (PARENT > 1) ? $clog2(PARENT) : 1,
    parameter int LOG_SEQ    = $clog2(SEQ)
) (
    input  logic                     clk,
    input  logic                     rstn,
    input  logic                     callVld_i,
    input  logic [1:0]               retReq_i,
    input  logic [LOG_THREAD-1:0]    thread_i,
    input  logic [LOG_PARENT-1:0]    parent_i,
    input  logic [ARG_W-1:0]         pc_i,
    input  logic [ARG_NUM*ARG_W-1:0] args_i,
    input  logic [LOG_SEQ-1:0]       callSeq_i,
    output logic                     rdy_o,
    output logic                     ap_start_o,
    input  logic                     ap_ready_i,
    input  logic                     ap_done_i,
    input  logic [RET_DW-1:0]        ap_return_i,
    output logic [ARG_NUM*ARG_W-1:0] args_o,
    output logic [ARG_W-1:0]         pc_o,
    output logic                     done_o,
    output logic                     retVld_o,
    input  logic                     retRdy_i,
    output logic [RET_DW-1:0]        retDin_o,
    output logic [LOG_THREAD-1:0]    retThread_o,
    output logic [LOG_PARENT-1:0]    parentMod_o,
    output logic [LOG_SEQ-1:0]       retSeq_o,
    output logic                     retMode_o,
    output logic                     err_o
);

    state_t    state_r, state_s;
    call_ctx_t cin_s, act_s;
    logic      push_s, pop_s, full_s, empty_s, pending_s;
    logic      enter_run_s, done_ok_s;
    logic      live_r, start_r, done_r, ret_vld_r, ret_mode_r, err_r;
    logic [RET_DW-1:0]     ret_din_r;
    logic [LOG_THREAD-1:0] ret_thread_r;
    logic [LOG_PARENT-1:0] ret_parent_r;
    logic [LOG_SEQ-1:0]    ret_seq_r;

    assign cin_s.thread   = thread_i;
    assign cin_s.parent   = parent_i;
    assign cin_s.pc       = pc_i;
    assign cin_s.args     = args_i;
    assign cin_s.call_seq = callSeq_i;
    assign cin_s.ret_req  = retReq_i;

    // rdy stays low until the first edge after reset so every output resets to 0.
`ifdef FUNC_CHILD_CALLBUF_EN
    assign rdy_o = live_r & !full_s;
`else
    assign rdy_o = live_r & !full_s & (state_r == ST_IDLE);
`endif

    assign push_s    = callVld_i & rdy_o;
    assign done_ok_s = ap_done_i & (state_r == ST_RUN) & !empty_s;

    func_child_ctx_buf u_ctx (
        .clk     (clk),
        .rstn    (rstn),
        .push    (push_s),
        .din     (cin_s),
        .pop     (pop_s),
        .act     (act_s),
        .full    (full_s),
        .empty   (empty_s),
        .pending (pending_s)
    );

    // Next-state, context pop and run-entry decode.
    always_comb begin
        state_s     = state_r;
        pop_s       = 1'b0;
        enter_run_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (push_s) begin
                    state_s     = ST_RUN;
                    enter_run_s = 1'b1;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (done_ok_s && act_s.ret_req[0]) begin
                    state_s = ST_RET;
                end else if (done_ok_s) begin
                    pop_s = 1'b1;
                    if (pending_s || push_s) begin
                        state_s     = ST_RUN;
                        enter_run_s = 1'b1;
                    end else begin
                        state_s = ST_IDLE;
                    end
                end else begin
                    state_s = ST_RUN;
                end
            end
            ST_RET: begin
                if (retRdy_i) begin
                    pop_s = 1'b1;
                    if (pending_s || push_s) begin
                        state_s     = ST_RUN;
                        enter_run_s = 1'b1;
                    end else begin
                        state_s = ST_IDLE;
                    end
                end else begin
                    state_s = ST_RET;
                end
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // State register and all registered handshake/return outputs.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_r      <= ST_IDLE;
            live_r       <= 1'b0;
            start_r      <= 1'b0;
            done_r       <= 1'b0;
            ret_vld_r    <= 1'b0;
            ret_din_r    <= '0;
            ret_thread_r <= '0;
            ret_parent_r <= '0;
            ret_seq_r    <= '0;
            ret_mode_r   <= 1'b0;
            err_r        <= 1'b0;
        end else begin
            state_r <= state_s;
            live_r  <= 1'b1;
            done_r  <= done_ok_s;
            err_r   <= err_r | (callVld_i & !rdy_o) | (ap_done_i & !done_ok_s);
            if (enter_run_s) begin
                start_r <= 1'b1;
            end else if ((state_r == ST_RUN) && ap_ready_i) begin
                start_r <= 1'b0;
            end
            if (done_ok_s && act_s.ret_req[0]) begin
                ret_vld_r    <= 1'b1;
                ret_din_r    <= ap_return_i;
                ret_thread_r <= act_s.thread;
                ret_parent_r <= act_s.parent;
                ret_seq_r    <= act_s.call_seq;
                ret_mode_r   <= act_s.ret_req[1];
            end else if ((state_r == ST_RET) && retRdy_i) begin
                ret_vld_r <= 1'b0;
            end
        end
    end

    assign ap_start_o  = start_r;
    assign done_o      = done_r;
    assign retVld_o    = ret_vld_r;
    assign retDin_o    = ret_din_r;
    assign retThread_o = ret_thread_r;
    assign parentMod_o = ret_parent_r;
    assign retSeq_o    = ret_seq_r;
    assign retMode_o   = ret_mode_r;
    assign err_o       = err_r;
    assign args_o      = act_s.args;
    assign pc_o        = act_s.pc;

endmodule

// File: tb/tb_func_child_port.sv
// tb_func_child_port: directed bench for func_child_port with a return scoreboard.
// Expected returns are queued when a call is driven and compared when retVld_o shows.
module tb_func_child_port;

    logic         clk;
    logic         rstn;
    logic         callVld_i;
    logic [1:0]   retReq_i;
    logic [3:0]   thread_i;
    logic [4:0]   parent_i;
    logic [31:0]  pc_i;
    logic [255:0] args_i;
    logic [2:0]   callSeq_i;
    logic         rdy_o, ap_start_o, ap_ready_i, ap_done_i;
    logic [31:0]  ap_return_i;
    logic [255:0] args_o;
    logic [31:0]  pc_o;
    logic         done_o, retVld_o, retRdy_i;
    logic [31:0]  retDin_o;
    logic [3:0]   retThread_o;
    logic [4:0]   parentMod_o;
    logic [2:0]   retSeq_o;
    logic         retMode_o, err_o;

    typedef struct packed {
        logic [31:0] din;
        logic [3:0]  thr;
        logic [4:0]  par;
        logic [2:0]  seq;
        logic        mode;
    } ret_t;

    ret_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    func_child_port dut (
        .clk(clk), .rstn(rstn), .callVld_i(callVld_i), .retReq_i(retReq_i),
        .thread_i(thread_i), .parent_i(parent_i), .pc_i(pc_i), .args_i(args_i),
        .callSeq_i(callSeq_i), .rdy_o(rdy_o), .ap_start_o(ap_start_o),
        .ap_ready_i(ap_ready_i), .ap_done_i(ap_done_i), .ap_return_i(ap_return_i),
        .args_o(args_o), .pc_o(pc_o), .done_o(done_o), .retVld_o(retVld_o),
        .retRdy_i(retRdy_i), .retDin_o(retDin_o), .retThread_o(retThread_o),
        .parentMod_o(parentMod_o), .retSeq_o(retSeq_o), .retMode_o(retMode_o),
        .err_o(err_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [255:0] mk_args(input logic [31:0] seed);
        logic [255:0] a;
        for (int i = 0; i < 8; i++) a[i*32 +: 32] = seed + 32'(i);
        return a;
    endfunction

    // Compare the return channel against the scoreboard head.
    task automatic chk_ret(input string tag);
        ret_t obs;
        obs = '{din: retDin_o, thr: retThread_o, par: parentMod_o, seq: retSeq_o, mode: retMode_o};
        chk({tag, "_vld"}, 256'(retVld_o), 256'd1);
        if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $error("FAIL %s: observed=return with scoreboard empty expected=no return", tag);
        end else begin
            chk(tag, 256'(obs), 256'(exp_q[0]));
        end
    endtask

    task automatic drive_call(input logic [3:0] thr, input logic [4:0] par, input logic [2:0] seq,
                              input logic [1:0] rr, input logic [31:0] seed, input logic [31:0] result);
        callVld_i = 1'b1;
        thread_i  = thr;
        parent_i  = par;
        callSeq_i = seq;
        retReq_i  = rr;
        pc_i      = 32'h100 + seed;
        args_i    = mk_args(seed);
        if (rr[0]) exp_q.push_back('{din: result, thr: thr, par: par, seq: seq, mode: rr[1]});
    endtask

    initial begin
        rstn = 1'b0; callVld_i = 1'b0; retReq_i = 2'b00; thread_i = 4'd0; parent_i = 5'd0;
        pc_i = 32'd0; args_i = 256'd0; callSeq_i = 3'd0; ap_ready_i = 1'b0; ap_done_i = 1'b0;
        ap_return_i = 32'd0; retRdy_i = 1'b0;
        #22;
        chk("rst_outputs", {rdy_o, ap_start_o, done_o, retVld_o, err_o, retMode_o}, 256'd0);
        chk("rst_data", {args_o, pc_o, retDin_o, retThread_o, parentMod_o, retSeq_o}, 256'd0);
        tick();
        rstn = 1'b1;
        tick();
        chk("idle_rdy", 256'(rdy_o), 256'd1);

        // Single call with return, kernel done after four cycles.
        drive_call(4'd3, 5'd5, 3'd2, 2'b11, 32'h10, 32'h1234);
        tick();
        callVld_i = 1'b0;
        chk("start_after_capture", 256'(ap_start_o), 256'd1);
        chk("args_latched", {args_o, pc_o}, {mk_args(32'h10), 32'h110});
`ifndef FUNC_CHILD_CALLBUF_EN
        chk("rdy_low_run", 256'(rdy_o), 256'd0);
`endif
        ap_ready_i = 1'b1;
        tick();
        ap_ready_i = 1'b0;
        chk("start_drop_on_ready", 256'(ap_start_o), 256'd0);
        tick();
        tick();
        ap_done_i = 1'b1; ap_return_i = 32'h1234;
        tick();
        ap_done_i = 1'b0; ap_return_i = 32'h0;
        chk("done_pulse", 256'(done_o), 256'd1);
        chk_ret("ret1");

        // Back-pressure for ten cycles, with an illegal call in the middle.
        for (int i = 0; i < 10; i++) begin
`ifndef FUNC_CHILD_CALLBUF_EN
            if (i == 3) begin
                callVld_i = 1'b1; thread_i = 4'd15; callSeq_i = 3'd7; retReq_i = 2'b01;
            end
`endif
            tick();
            callVld_i = 1'b0;
            if (i == 0) chk("done_single", 256'(done_o), 256'd0);
            chk_ret("ret1_hold");
`ifndef FUNC_CHILD_CALLBUF_EN
            chk("rdy_low_ret", 256'(rdy_o), 256'd0);
`endif
        end
`ifndef FUNC_CHILD_CALLBUF_EN
        chk("err_illegal", 256'(err_o), 256'd1);
`endif
        retRdy_i = 1'b1;
        tick();
        retRdy_i = 1'b0;
        if (exp_q.size() > 0) void'(exp_q.pop_front());
        chk("ret1_pop", {retVld_o, rdy_o}, {1'b0, 1'b1});

        // No-return call with ready and done together.
        drive_call(4'd1, 5'd2, 3'd4, 2'b00, 32'h20, 32'h0);
        tick();
        callVld_i = 1'b0;
        chk("nr_start", 256'(ap_start_o), 256'd1);
        ap_ready_i = 1'b1; ap_done_i = 1'b1; ap_return_i = 32'hDEAD;
        tick();
        ap_ready_i = 1'b0; ap_done_i = 1'b0;
        chk("nr_done", {done_o, retVld_o, ap_start_o, rdy_o}, {1'b1, 1'b0, 1'b0, 1'b1});
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("nr_no_ret", {done_o, retVld_o}, 256'd0);
        end

        // Reset while a returning call is in RUN; that return is lost.
        drive_call(4'd6, 5'd6, 3'd6, 2'b00, 32'h30, 32'h0);
        retReq_i = 2'b11;
        tick();
        callVld_i = 1'b0;
        chk("mid_start", 256'(ap_start_o), 256'd1);
        rstn = 1'b0;
        #1;
        chk("mid_rst_outputs", {rdy_o, ap_start_o, done_o, retVld_o, err_o}, 256'd0);
        chk("mid_rst_data", {args_o, pc_o, retDin_o}, 256'd0);
        tick();
        rstn = 1'b1;
        tick();
        chk("post_rst", {rdy_o, err_o, retVld_o}, {1'b1, 1'b0, 1'b0});

        // Clean call after reset; return accepted immediately.
        drive_call(4'd9, 5'd17, 3'd7, 2'b01, 32'h40, 32'hCAFE);
        tick();
        callVld_i = 1'b0;
        ap_ready_i = 1'b1; ap_done_i = 1'b1; ap_return_i = 32'hCAFE; retRdy_i = 1'b1;
        tick();
        ap_ready_i = 1'b0; ap_done_i = 1'b0;
        chk("clean_done", 256'(done_o), 256'd1);
        chk_ret("ret_clean");
        tick();
        retRdy_i = 1'b0;
        if (exp_q.size() > 0) void'(exp_q.pop_front());
        chk("clean_pop", {retVld_o, rdy_o, err_o}, {1'b0, 1'b1, 1'b0});

`ifdef FUNC_CHILD_CALLBUF_EN
        // Two pipelined calls, seq 1 then 2, plus an illegal call while full.
        drive_call(4'd2, 5'd3, 3'd1, 2'b11, 32'h50, 32'hA1);
        tick();
        drive_call(4'd4, 5'd8, 3'd2, 2'b01, 32'h60, 32'hB2);
        tick();
        callVld_i = 1'b0;
        chk("buf_full_rdy", 256'(rdy_o), 256'd0);
        callVld_i = 1'b1;
        tick();
        callVld_i = 1'b0;
        chk("buf_err", 256'(err_o), 256'd1);
        ap_ready_i = 1'b1; ap_done_i = 1'b1; ap_return_i = 32'hA1;
        tick();
        ap_ready_i = 1'b0; ap_done_i = 1'b0;
        chk_ret("buf_ret1");
        retRdy_i = 1'b1;
        tick();
        retRdy_i = 1'b0;
        if (exp_q.size() > 0) void'(exp_q.pop_front());
        chk("buf_second_start", {ap_start_o, retVld_o}, {1'b1, 1'b0});
        chk("buf_second_args", 256'(args_o), mk_args(32'h60));
        ap_ready_i = 1'b1; ap_done_i = 1'b1; ap_return_i = 32'hB2;
        tick();
        ap_ready_i = 1'b0; ap_done_i = 1'b0;
        chk_ret("buf_ret2");
        retRdy_i = 1'b1;
        tick();
        retRdy_i = 1'b0;
        if (exp_q.size() > 0) void'(exp_q.pop_front());
        chk("buf_idle", {retVld_o, rdy_o}, {1'b0, 1'b1});
`endif

        // ap_done outside RUN is ignored but flagged.
        ap_done_i = 1'b1;
        tick();
        ap_done_i = 1'b0;
        chk("done_outside_run", {err_o, done_o, retVld_o}, {1'b1, 1'b0, 1'b0});
        tick();
        chk("err_sticky", 256'(err_o), 256'd1);
        chk("sb_empty", 256'(exp_q.size()), 256'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
